// File: rtl/fast_field_splitter.sv
// FAST decoder front-end: splits stop-bit-delimited fields out of raw beats onto SUP_PATHS lanes.
// Define FIELD_OVERFLOW_CHECK_EN to flag fields longer than MAX_FIELD_BYTES encoded bytes.
module fast_field_splitter #(
   parameter int unsigned BEAT_WIDTH      = 64,
   parameter int unsigned SUP_PATHS       = 4,
   parameter int unsigned MAX_FIELD_BYTES = 10
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [BEAT_WIDTH-1:0]                in_data,
   input  logic [BEAT_WIDTH/8-1:0]              in_keep,
   input  logic                                 in_valid,
   input  logic                                 in_sop,
   input  logic                                 in_eop,
   output logic                                 in_ready,
   output logic [SUP_PATHS-1:0][BEAT_WIDTH+1:0] dins,
   output logic [SUP_PATHS-1:0]                 field_valids,
   output logic [SUP_PATHS-1:0]                 field_complete,
   output logic                                 new_message,
   output logic                                 msg_error,
   output logic                                 msg_abort
);
   localparam int unsigned BW = BEAT_WIDTH;
   localparam int unsigned NB = BEAT_WIDTH / 8;
   localparam int unsigned PW = $clog2(NB + 1);
   localparam int unsigned NW = $clog2(SUP_PATHS + 1);
   localparam int unsigned LW = (SUP_PATHS > 1) ? $clog2(SUP_PATHS) : 1;

   if ((BW % 8) != 0 || BW < 8 || MAX_FIELD_BYTES == 0) begin : g_bad_cfg
      $error("fast_field_splitter: unsupported parameter set");
   end

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t                       r_state;
   logic [BW-1:0]                r_beat;
   logic [NB-1:0]                r_keep;
   logic                         r_eop;
   logic [PW-1:0]                r_ptr;
   logic [BW-1:0]                r_acc;
   logic                         r_open;
   logic                         r_pend;
   logic                         r_msg_open;
   logic [SUP_PATHS-1:0][BW+1:0] r_dins;
   logic [SUP_PATHS-1:0]         r_fv;
   logic [SUP_PATHS-1:0]         r_fc;
   logic                         r_newmsg;
   logic                         r_err;
   logic                         r_abort;

   logic [BW-1:0]                w_acc;
   logic                         w_open;
   logic                         w_pend;
   logic                         w_err;
   logic                         w_stall;
   logic                         w_done;
   logic                         w_newmsg;
   logic [PW-1:0]                w_ptr;
   logic [NW-1:0]                w_n;
   logic [LW-1:0]                w_li;
   logic [7:0]                   w_byte;
   logic [SUP_PATHS-1:0][BW+1:0] w_dins;
   logic [SUP_PATHS-1:0]         w_fv;
   logic [SUP_PATHS-1:0]         w_fc;
   logic                         w_accept;
   logic                         w_open_nx;

`ifdef FIELD_OVERFLOW_CHECK_EN
   localparam int unsigned CW = $clog2(MAX_FIELD_BYTES + 1);
   logic [CW-1:0]                r_cnt;
   logic [CW-1:0]                w_cnt;
`endif

   // Scan the held beat from r_ptr, packing up to SUP_PATHS terminated fields into lanes.
   always_comb begin
      w_acc    = r_acc;
      w_open   = r_open;
      w_pend   = r_pend;
      w_err    = 1'b0;
      w_stall  = 1'b0;
      w_done   = 1'b1;
      w_newmsg = 1'b0;
      w_ptr    = r_ptr;
      w_n      = '0;
      w_li     = '0;
      w_byte   = '0;
      w_dins   = '0;
      w_fv     = '0;
      w_fc     = '0;
`ifdef FIELD_OVERFLOW_CHECK_EN
      w_cnt    = r_cnt;
`endif
      if (r_state == S_SCAN) begin
         for (int b = 0; b < NB; b++) begin
            w_byte = r_beat[BW-1-8*b -: 8];
            if (!w_stall && r_keep[NB-1-b] && (PW'(b) >= r_ptr)) begin
               if (w_byte[7] && (w_n == NW'(SUP_PATHS))) begin
                  w_stall = 1'b1;
                  w_ptr   = PW'(b);
               end else begin
                  w_acc = {w_acc[BW-8:0], w_byte[6:0]};
`ifdef FIELD_OVERFLOW_CHECK_EN
                  if (w_cnt == CW'(MAX_FIELD_BYTES)) w_err = 1'b1;
                  else                               w_cnt = w_cnt + CW'(1);
                  if (w_byte[7]) w_cnt = '0;
`endif
                  if (w_byte[7]) begin
                     w_li         = w_n[LW-1:0];
                     w_dins[w_li] = {w_pend, 1'b0, w_acc};
                     w_fv[w_li]   = 1'b1;
                     w_fc[w_li]   = 1'b1;
                     w_newmsg     = w_newmsg | w_pend;
                     w_pend       = 1'b0;
                     w_acc        = '0;
                     w_open       = 1'b0;
                     w_n          = w_n + NW'(1);
                  end else begin
                     w_open = 1'b1;
                  end
               end
            end
         end
         // An open field at eop needs a lane of its own; if none is free, park ptr past the beat.
         if (!w_stall && r_eop && w_open) begin
            if (w_n == NW'(SUP_PATHS)) begin
               w_stall = 1'b1;
               w_ptr   = PW'(NB);
            end else begin
               w_li         = w_n[LW-1:0];
               w_dins[w_li] = {w_pend, 1'b0, w_acc};
               w_fv[w_li]   = 1'b1;
               w_newmsg     = w_newmsg | w_pend;
               w_pend       = 1'b0;
               w_acc        = '0;
               w_open       = 1'b0;
               w_err        = 1'b1;
               w_n          = w_n + NW'(1);
            end
         end
         if (!w_stall && r_eop && (w_n != '0)) begin
            w_li             = LW'(w_n - NW'(1));
            w_dins[w_li][BW] = 1'b1;
         end
         w_done = !w_stall;
      end
   end

   assign in_ready  = rstn && w_done;
   assign w_accept  = in_valid && in_ready;
   assign w_open_nx = r_msg_open && !((r_state == S_SCAN) && w_done && r_eop);

   // Beat holding, scan progress and registered lane outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_beat     <= '0;
         r_keep     <= '0;
         r_eop      <= 1'b0;
         r_ptr      <= '0;
         r_acc      <= '0;
         r_open     <= 1'b0;
         r_pend     <= 1'b0;
         r_msg_open <= 1'b0;
         r_dins     <= '0;
         r_fv       <= '0;
         r_fc       <= '0;
         r_newmsg   <= 1'b0;
         r_err      <= 1'b0;
         r_abort    <= 1'b0;
`ifdef FIELD_OVERFLOW_CHECK_EN
         r_cnt      <= '0;
`endif
      end else begin
         r_dins   <= w_dins;
         r_fv     <= w_fv;
         r_fc     <= w_fc;
         r_newmsg <= w_newmsg;
         r_abort  <= w_accept && in_sop && w_open_nx;
         r_err    <= (w_accept && in_sop) ? 1'b0 : (r_err | w_err);
         if (r_state == S_SCAN) begin
            r_acc  <= w_acc;
            r_open <= w_open;
            r_pend <= w_pend;
`ifdef FIELD_OVERFLOW_CHECK_EN
            r_cnt  <= w_cnt;
`endif
            if (!w_done) begin
               r_ptr <= w_ptr;
            end else begin
               if (r_eop)     r_msg_open <= 1'b0;
               if (!w_accept) r_state    <= S_IDLE;
            end
         end
         if (w_accept) begin
            r_beat  <= in_data;
            r_keep  <= in_keep;
            r_eop   <= in_eop;
            r_ptr   <= '0;
            r_state <= S_SCAN;
            if (in_sop) begin
               r_acc      <= '0;
               r_open     <= 1'b0;
               r_pend     <= 1'b1;
               r_msg_open <= 1'b1;
`ifdef FIELD_OVERFLOW_CHECK_EN
               r_cnt      <= '0;
`endif
            end
         end
      end
   end

   assign dins           = r_dins;
   assign field_valids   = r_fv;
   assign field_complete = r_fc;
   assign new_message    = r_newmsg;
   assign msg_error      = r_err;
   assign msg_abort      = r_abort;

endmodule
